// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ID-stage instruction into ALU controls,
// registers it, and forwards EX/MEM and MEM/WB results onto the ALU operands.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        id_valid,
   input  logic [5:0]  id_opcode,
   input  logic [5:0]  id_funct,
   input  logic [4:0]  id_shamt,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [15:0] id_imm,
   input  logic        exmem_wr_en,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_result,
   input  logic        memwb_wr_en,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_result,
   output logic        ex_valid,
   output logic [3:0]  ex_aluCON,
   output logic [31:0] ex_in1,
   output logic [31:0] ex_in2,
   output logic [4:0]  ex_dst,
   output logic        ex_reg_write,
   output logic        ex_ov_chk,
   output logic        ex_illegal
);

   typedef enum logic [1:0] {
      SEL_RR    = 2'd0,
      SEL_SHIFT = 2'd1,
      SEL_IMM   = 2'd2
   } opsel_t;

   typedef struct packed {
      logic        valid;
      logic [3:0]  alu;
      opsel_t      sel;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic [4:0]  dst;
      logic        reg_write;
      logic        ov_chk;
      logic        illegal;
   } ex_t;

   ex_t         ex_r;
   ex_t         nxt_s;
   logic [3:0]  dec_alu_s;
   logic        dec_ov_s;
   logic        dec_legal_s;
   opsel_t      dec_sel_s;
   logic [31:0] dec_imm_s;
   logic [4:0]  dec_dst_s;
   logic [31:0] fwd_rs_s;
   logic [31:0] fwd_rt_s;

   // Register 0 is hard-wired, so it is never a forwarding target.
   function automatic logic [31:0] fwd(
      input logic [4:0]  r,
      input logic [31:0] d,
      input logic        em_en,
      input logic [4:0]  em_rd,
      input logic [31:0] em_res,
      input logic        mw_en,
      input logic [4:0]  mw_rd,
      input logic [31:0] mw_res
   );
      logic [31:0] v;
      if ((r != 5'd0) && em_en && (em_rd == r)) begin
         v = em_res;
      end else if ((r != 5'd0) && mw_en && (mw_rd == r)) begin
         v = mw_res;
      end else begin
         v = d;
      end
      return v;
   endfunction

   // Instruction decode of the ID-stage fields.
   always_comb begin
      dec_alu_s   = 4'h0;
      dec_ov_s    = 1'b0;
      dec_legal_s = 1'b0;
      dec_sel_s   = SEL_RR;
      dec_imm_s   = {16'h0000, id_imm};
      dec_dst_s   = id_rt;
      case (id_opcode)
         6'h00: begin
            dec_dst_s   = id_rd;
            dec_legal_s = 1'b1;
            case (id_funct)
               6'h20:   begin dec_alu_s = 4'h0; dec_ov_s = 1'b1; end
               6'h21:   dec_alu_s = 4'hE;
               6'h22:   begin dec_alu_s = 4'h1; dec_ov_s = 1'b1; end
               6'h23:   dec_alu_s = 4'hF;
               6'h24:   dec_alu_s = 4'h2;
               6'h25:   dec_alu_s = 4'h3;
               6'h26:   dec_alu_s = 4'h4;
               6'h27:   dec_alu_s = 4'h5;
               6'h00:   begin dec_alu_s = 4'h6; dec_sel_s = SEL_SHIFT; end
               6'h02:   begin dec_alu_s = 4'h7; dec_sel_s = SEL_SHIFT; end
               default: dec_legal_s = 1'b0;
            endcase
         end
         6'h08: begin
            dec_alu_s   = 4'h0;
            dec_ov_s    = 1'b1;
            dec_legal_s = 1'b1;
            dec_sel_s   = SEL_IMM;
            dec_imm_s   = {{16{id_imm[15]}}, id_imm};
         end
         6'h09: begin
            dec_alu_s   = 4'hE;
            dec_legal_s = 1'b1;
            dec_sel_s   = SEL_IMM;
            dec_imm_s   = {{16{id_imm[15]}}, id_imm};
         end
         6'h0C: begin dec_alu_s = 4'h2; dec_legal_s = 1'b1; dec_sel_s = SEL_IMM; end
         6'h0D: begin dec_alu_s = 4'h3; dec_legal_s = 1'b1; dec_sel_s = SEL_IMM; end
         6'h0E: begin dec_alu_s = 4'h4; dec_legal_s = 1'b1; dec_sel_s = SEL_IMM; end
         default: dec_legal_s = 1'b0;
      endcase
   end

   // Next register contents: flush beats stall; an empty ID slot becomes a bubble.
   always_comb begin
      nxt_s = '0;
      if (flush) begin
         nxt_s = '0;
      end else if (stall) begin
         nxt_s = ex_r;
      end else if (id_valid) begin
         nxt_s.valid     = 1'b1;
         nxt_s.alu       = dec_alu_s;
         nxt_s.sel       = dec_sel_s;
         nxt_s.rs        = id_rs;
         nxt_s.rt        = id_rt;
         nxt_s.rs_data   = id_rs_data;
         nxt_s.rt_data   = id_rt_data;
         nxt_s.imm       = dec_imm_s;
         nxt_s.shamt     = id_shamt;
         nxt_s.dst       = dec_dst_s;
         nxt_s.reg_write = dec_legal_s & (dec_dst_s != 5'd0);
         nxt_s.ov_chk    = dec_ov_s;
         nxt_s.illegal   = ~dec_legal_s;
      end else begin
         nxt_s = '0;
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_r <= '0;
      end else begin
         ex_r <= nxt_s;
      end
   end

   // Forwarding and operand selection track their inputs with no delay.
   always_comb begin
      fwd_rs_s = fwd(ex_r.rs, ex_r.rs_data, exmem_wr_en, exmem_rd, exmem_result,
                     memwb_wr_en, memwb_rd, memwb_result);
      fwd_rt_s = fwd(ex_r.rt, ex_r.rt_data, exmem_wr_en, exmem_rd, exmem_result,
                     memwb_wr_en, memwb_rd, memwb_result);
      case (ex_r.sel)
         SEL_SHIFT: begin ex_in1 = fwd_rt_s; ex_in2 = {27'd0, ex_r.shamt}; end
         SEL_IMM:   begin ex_in1 = fwd_rs_s; ex_in2 = ex_r.imm; end
         default:   begin ex_in1 = fwd_rs_s; ex_in2 = fwd_rt_s; end
      endcase
   end

   assign ex_valid     = ex_r.valid;
   assign ex_aluCON    = ex_r.alu;
   assign ex_dst       = ex_r.dst;
   assign ex_reg_write = ex_r.reg_write;
   assign ex_ov_chk    = ex_r.ov_chk;
   assign ex_illegal   = ex_r.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: an instruction-level model predicts every output on each
// falling edge, and directed vectors pin the model with hand-computed values.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
   logic [5:0]  id_opcode = '0, id_funct = '0;
   logic [4:0]  id_shamt = '0, id_rs = '0, id_rt = '0, id_rd = '0;
   logic [31:0] id_rs_data = '0, id_rt_data = '0;
   logic [15:0] id_imm = '0;
   logic        exmem_wr_en = 1'b0, memwb_wr_en = 1'b0;
   logic [4:0]  exmem_rd = '0, memwb_rd = '0;
   logic [31:0] exmem_result = '0, memwb_result = '0;
   logic        ex_valid, ex_reg_write, ex_ov_chk, ex_illegal;
   logic [3:0]  ex_aluCON;
   logic [31:0] ex_in1, ex_in2;
   logic [4:0]  ex_dst;

   int vectors = 0;
   int miscompares = 0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_opcode(id_opcode), .id_funct(id_funct), .id_shamt(id_shamt),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ex_aluCON(ex_aluCON), .ex_in1(ex_in1), .ex_in2(ex_in2),
      .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_ov_chk(ex_ov_chk),
      .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   // The model holds the raw instruction sitting in EX.
   typedef struct packed {
      logic        v;
      logic [5:0]  op, fn;
      logic [4:0]  sh, rs, rt, rd;
      logic [31:0] rsd, rtd;
      logic [15:0] imm;
   } ins_t;

   ins_t m;

   always @(posedge clk or posedge rst) begin
      if (rst || flush) m = '0;
      else if (!stall) begin
         if (id_valid)
            m = '{1'b1, id_opcode, id_funct, id_shamt, id_rs, id_rt, id_rd,
                  id_rs_data, id_rt_data, id_imm};
         else
            m = '0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] d);
      if (r == 5'd0) return d;
      if (exmem_wr_en && exmem_rd == r) return exmem_result;
      if (memwb_wr_en && memwb_rd == r) return memwb_result;
      return d;
   endfunction

   // Compare process: predicted outputs from the instruction table and forwarding rules.
   always @(negedge clk) begin
      logic [3:0]  alu;
      logic        ov, legal;
      logic [31:0] e1, e2;
      logic [4:0]  dst;
      alu = 4'h0; ov = 1'b0; legal = 1'b1; e1 = 32'd0; e2 = 32'd0; dst = 5'd0;
      if (m.v) begin
         dst = (m.op == 6'h00) ? m.rd : m.rt;
         e1 = mfwd(m.rs, m.rsd);
         e2 = mfwd(m.rt, m.rtd);
         if (m.op == 6'h00) begin
            case (m.fn)
               6'h20: begin alu = 4'h0; ov = 1'b1; end
               6'h21: alu = 4'hE;
               6'h22: begin alu = 4'h1; ov = 1'b1; end
               6'h23: alu = 4'hF;
               6'h24: alu = 4'h2;
               6'h25: alu = 4'h3;
               6'h26: alu = 4'h4;
               6'h27: alu = 4'h5;
               6'h00: begin alu = 4'h6; e1 = mfwd(m.rt, m.rtd); e2 = 32'(m.sh); end
               6'h02: begin alu = 4'h7; e1 = mfwd(m.rt, m.rtd); e2 = 32'(m.sh); end
               default: legal = 1'b0;
            endcase
         end else begin
            case (m.op)
               6'h08: begin alu = 4'h0; ov = 1'b1; e2 = 32'(signed'(m.imm)); end
               6'h09: begin alu = 4'hE; e2 = 32'(signed'(m.imm)); end
               6'h0C: begin alu = 4'h2; e2 = {16'h0, m.imm}; end
               6'h0D: begin alu = 4'h3; e2 = {16'h0, m.imm}; end
               6'h0E: begin alu = 4'h4; e2 = {16'h0, m.imm}; end
               default: legal = 1'b0;
            endcase
         end
      end
      chk("valid", 32'(ex_valid), 32'(m.v));
      chk("aluCON", 32'(ex_aluCON), 32'(alu));
      chk("ov_chk", 32'(ex_ov_chk), 32'(ov));
      chk("illegal", 32'(ex_illegal), 32'(m.v && !legal));
      chk("reg_write", 32'(ex_reg_write), 32'(m.v && legal && dst != 5'd0));
      if (!m.v || legal) begin
         chk("dst", 32'(ex_dst), 32'(dst));
         chk("in1", ex_in1, e1);
         chk("in2", ex_in2, e2);
      end
   end

   task automatic setid(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [15:0] imm);
      id_valid = v; id_opcode = op; id_funct = fn; id_shamt = sh;
      id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   logic [5:0]  t_op [10] = '{6'h0E, 6'h0D, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h09};
   logic [5:0]  t_fn [10] = '{6'h00, 6'h00, 6'h02, 6'h27, 6'h23, 6'h24, 6'h25, 6'h26, 6'h00, 6'h00};
   logic        t_v  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [15:0] t_im [10] = '{16'h8001, 16'h00F0, 16'h0000, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'h8000};

   initial begin
      repeat (2) tick;
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk("rst_in1", ex_in1, 32'd0);
      rst = 1'b0;

      setid(1'b1, 6'h00, 6'h20, 5'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0000);
      tick;
      chk("add_alu", 32'(ex_aluCON), 32'h0);
      chk("add_in1", ex_in1, 32'd5);
      chk("add_in2", ex_in2, 32'd7);
      chk("add_dst", 32'(ex_dst), 32'd3);
      chk("add_rw", 32'(ex_reg_write), 32'd1);
      chk("add_ov", 32'(ex_ov_chk), 32'd1);

      setid(1'b1, 6'h08, 6'h00, 5'd0, 5'd4, 5'd6, 5'd0, 32'd10, 32'd0, 16'hFFFF);
      tick;
      chk("addi_in2", ex_in2, 32'hFFFF_FFFF);
      chk("addi_dst", 32'(ex_dst), 32'd6);
      setid(1'b1, 6'h0C, 6'h00, 5'd0, 5'd4, 5'd6, 5'd0, 32'd10, 32'd0, 16'hFFFF);
      tick;
      chk("andi_in2", ex_in2, 32'h0000_FFFF);
      chk("andi_alu", 32'(ex_aluCON), 32'h2);

      setid(1'b1, 6'h00, 6'h20, 5'd0, 5'd5, 5'd5, 5'd7, 32'd1, 32'd2, 16'h0000);
      exmem_wr_en = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAA;
      memwb_wr_en = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hBB;
      tick;
      chk("fwd_em_in1", ex_in1, 32'hAA);
      chk("fwd_em_in2", ex_in2, 32'hAA);
      exmem_wr_en = 1'b0;
      #1;
      chk("fwd_mw_in1", ex_in1, 32'hBB);
      chk("fwd_mw_in2", ex_in2, 32'hBB);

      memwb_wr_en = 1'b0;
      exmem_wr_en = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h1234;
      setid(1'b1, 6'h00, 6'h21, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'h0000);
      tick;
      chk("r0_in1", ex_in1, 32'd0);
      chk("r0_rw", 32'(ex_reg_write), 32'd0);
      chk("r0_alu", 32'(ex_aluCON), 32'hE);
      exmem_wr_en = 1'b0;

      setid(1'b1, 6'h00, 6'h22, 5'd0, 5'd1, 5'd2, 5'd9, 32'd20, 32'd3, 16'h0000);
      tick;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         setid(1'b1, 6'h00, 6'h24 + 6'(i), 5'd0, 5'(10 + i), 5'd11, 5'd12, 32'(i), 32'd9, 16'h0000);
         tick;
         chk("stall_alu", 32'(ex_aluCON), 32'h1);
         chk("stall_dst", 32'(ex_dst), 32'd9);
         chk("stall_in1", ex_in1, 32'd20);
      end
      flush = 1'b1;
      tick;
      chk("flush_valid", 32'(ex_valid), 32'd0);
      chk("flush_dst", 32'(ex_dst), 32'd0);
      stall = 1'b0; flush = 1'b0;
      setid(1'b1, 6'h00, 6'h18, 5'd0, 5'd1, 5'd2, 5'd4, 32'd1, 32'd1, 16'h0000);
      tick;
      chk("ill_flag", 32'(ex_illegal), 32'd1);
      chk("ill_rw", 32'(ex_reg_write), 32'd0);

      setid(1'b1, 6'h00, 6'h00, 5'd4, 5'd0, 5'd2, 5'd8, 32'd0, 32'h1, 16'h0000);
      tick;
      chk("sll_alu", 32'(ex_aluCON), 32'h6);
      chk("sll_in1", ex_in1, 32'h1);
      chk("sll_in2", ex_in2, 32'd4);
      #1 rst = 1'b1;
      #1;
      chk("rstp_valid", 32'(ex_valid), 32'd0);
      chk("rstp_alu", 32'(ex_aluCON), 32'd0);
      chk("rstp_in1", ex_in1, 32'd0);
      chk("rstp_in2", ex_in2, 32'd0);
      chk("rstp_dst", 32'(ex_dst), 32'd0);
      #1 rst = 1'b0;
      setid(1'b1, 6'h00, 6'h25, 5'd0, 5'd3, 5'd6, 5'd7, 32'h0F, 32'hF0, 16'h0000);
      tick;
      chk("post_rst_alu", 32'(ex_aluCON), 32'h3);

      memwb_wr_en = 1'b1; memwb_rd = 5'd6; memwb_result = 32'hC0DE;
      for (int i = 0; i < 10; i++) begin
         setid(t_v[i], t_op[i], t_fn[i], 5'(i), 5'd3, 5'd6, 5'(i + 1),
               32'(100 + i), 32'(200 + i), t_im[i]);
         tick;
      end
      setid(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'h0000);
      tick;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
